// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared constants and types for the two-port single-port-SRAM arbiter.
//   PORT_IF is the instruction-fetch requester, PORT_LS the load/store one.
//   infl_t describes the access issued to the SRAM in the previous cycle,
//   whose response is presented in the current cycle.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int N_PORTS = 2;
   localparam int PORT_IF = 0;
   localparam int PORT_LS = 1;

   typedef struct packed {
      logic v;     // an access was issued last cycle
      logic port;  // requester that owns it
      logic we;    // it was a write (response carries no data)
   } infl_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. When both requesters are eligible the one
//   that was not granted last wins; a single eligible requester always wins.
//   last_grant only moves when a grant is actually given, and resets to 0 so
//   that port 1 is favoured first.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   elig[1:0]    per-port eligibility this cycle
//   gnt_v        a grant is given this cycle (combinational)
//   gnt_port     index of the granted port (valid when gnt_v)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] elig,
   output logic       gnt_v,
   output logic       gnt_port
);

   logic last_grant;

   always_comb begin
      gnt_v = |elig;
      if (elig == 2'b11) begin
         gnt_port = ~last_grant;
      end else begin
         gnt_port = elig[1];
      end
   end

   // NOTE: clocked state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b0;
      end else if (gnt_v) begin
         last_grant <= gnt_port;
      end
   end

endmodule

// File: rtl/sram_sp_arb.sv
// -----------------------------------------------------------------------------
// sram_sp_arb
//   Shares one single-port SRAM between an instruction-fetch port (0) and a
//   load/store port (1). At most one access is issued per cycle, chosen
//   round-robin. The response (read data, or a zero-data write ack) appears
//   the cycle after the request handshake on a per-port valid/ready channel.
//   If the requester is not ready, the response is parked in a one-entry hold
//   buffer so the SRAM read is never repeated; a port with a parked (or
//   about-to-be-parked) response is not granted.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/we [2]     request handshake and direction per port
//   req_be    [2*N_DM]         byte enables, port p at [p*N_DM +: N_DM]
//   req_addr  [2*N_AW]         word address, port p at [p*N_AW +: N_AW]
//   req_wdata [2*N_DW]         write data,   port p at [p*N_DW +: N_DW]
//   rsp_valid/ready [2]        response handshake per port
//   rsp_rdata [2*N_DW]         read data per port, 0 for write acks
//   sram_csn/wen/web           active-low SRAM controls
//   sram_addr/din/dout         SRAM address and data; dout valid the cycle
//                              after a read issue
// -----------------------------------------------------------------------------
module sram_sp_arb
   import sram_arb_pkg::*;
#(
   parameter int N_DW = 32,
   parameter int N_DP = 512,
   parameter int N_DM = N_DW / 8,
   parameter int N_AW = (N_DP > 1) ? $clog2(N_DP) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_PORTS-1:0]        req_valid,
   output logic [N_PORTS-1:0]        req_ready,
   input  logic [N_PORTS-1:0]        req_we,
   input  logic [N_PORTS*N_DM-1:0]   req_be,
   input  logic [N_PORTS*N_AW-1:0]   req_addr,
   input  logic [N_PORTS*N_DW-1:0]   req_wdata,
   output logic [N_PORTS-1:0]        rsp_valid,
   input  logic [N_PORTS-1:0]        rsp_ready,
   output logic [N_PORTS*N_DW-1:0]   rsp_rdata,
   output logic                      sram_csn,
   output logic                      sram_wen,
   output logic [N_DM-1:0]           sram_web,
   output logic [N_AW-1:0]           sram_addr,
   output logic [N_DW-1:0]           sram_din,
   input  logic [N_DW-1:0]           sram_dout
);

   infl_t              infl_q, infl_d;
   logic [N_PORTS-1:0] hold_v;
   logic [N_DW-1:0]    hold_data [N_PORTS];
   logic [N_DW-1:0]    infl_data;
   logic [N_PORTS-1:0] elig;
   logic               gnt_v;
   logic               gnt_port;

   // Granted port's request fields.
   logic               g_we;
   logic [N_DM-1:0]    g_be;
   logic [N_AW-1:0]    g_addr;
   logic [N_DW-1:0]    g_wdata;

   // Data returned by last cycle's access: writes acknowledge with zero.
   assign infl_data = infl_q.we ? '0 : sram_dout;

   // A port is blocked while its response is parked, or while its fresh
   // response is about to be parked because the requester is not ready.
   // rst_n gates eligibility so the combinational issue outputs also hold
   // their reset values for as long as reset is asserted.
   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         elig[p] = rst_n & req_valid[p] & ~hold_v[p] &
                   ~(infl_q.v & (infl_q.port == 1'(p)) & ~rsp_ready[p]);
      end
   end

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .elig     (elig),
      .gnt_v    (gnt_v),
      .gnt_port (gnt_port)
   );

   always_comb begin
      g_we    = gnt_port ? req_we[1]               : req_we[0];
      g_be    = gnt_port ? req_be[N_DM +: N_DM]    : req_be[0 +: N_DM];
      g_addr  = gnt_port ? req_addr[N_AW +: N_AW]  : req_addr[0 +: N_AW];
      g_wdata = gnt_port ? req_wdata[N_DW +: N_DW] : req_wdata[0 +: N_DW];
   end

   // Issue: SRAM controls, request accept and the next inflight record.
   // NOTE: every output of a combinational block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      req_ready = '0;
      sram_csn  = 1'b1;
      sram_wen  = 1'b1;
      sram_web  = '1;
      sram_addr = '0;
      sram_din  = '0;
      infl_d    = '0;
      if (gnt_v) begin
         req_ready[gnt_port] = 1'b1;
         sram_csn    = 1'b0;
         sram_wen    = ~g_we;
         sram_web    = g_we ? ~g_be : '1;
         sram_addr   = g_addr;
         sram_din    = g_wdata;
         infl_d.v    = 1'b1;
         infl_d.port = gnt_port;
         infl_d.we   = g_we;
      end
   end

   // Response: a parked entry and a same-port inflight never coexist.
   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         rsp_valid[p] = hold_v[p] | (infl_q.v & (infl_q.port == 1'(p)));
         rsp_rdata[p*N_DW +: N_DW] = hold_v[p] ? hold_data[p] : infl_data;
      end
   end

   // NOTE: hold_data is only two words, so it is reset along with its valid
   // bit; a deep storage array would be left unreset instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infl_q <= '0;
         hold_v <= '0;
         for (int p = 0; p < N_PORTS; p++) begin
            hold_data[p] <= '0;
         end
      end else begin
         infl_q <= infl_d;
         for (int p = 0; p < N_PORTS; p++) begin
            if (infl_q.v && (infl_q.port == 1'(p)) && !rsp_ready[p]) begin
               hold_v[p]    <= 1'b1;
               hold_data[p] <= infl_data;
            end else if (hold_v[p] && rsp_ready[p]) begin
               hold_v[p] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_sp_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_sp_arb
//   Bench for sram_sp_arb with a behavioural SRAM and a reference model that
//   tracks memory contents, pending responses per port and the round-robin
//   turn, all at transaction level.
// -----------------------------------------------------------------------------
module tb_sram_sp_arb;

   localparam int N_DW = 32;
   localparam int N_DP = 512;
   localparam int N_DM = N_DW / 8;
   localparam int N_AW = $clog2(N_DP);

   typedef struct {
      logic            we;
      logic [N_DM-1:0] be;
      logic [N_AW-1:0] addr;
      logic [N_DW-1:0] wdata;
   } req_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          req_valid = '0;
   logic [1:0]          req_ready;
   logic [1:0]          req_we = '0;
   logic [2*N_DM-1:0]   req_be = '0;
   logic [2*N_AW-1:0]   req_addr = '0;
   logic [2*N_DW-1:0]   req_wdata = '0;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready = '0;
   logic [2*N_DW-1:0]   rsp_rdata;
   logic                sram_csn;
   logic                sram_wen;
   logic [N_DM-1:0]     sram_web;
   logic [N_AW-1:0]     sram_addr;
   logic [N_DW-1:0]     sram_din;
   logic [N_DW-1:0]     sram_dout = '0;

   int checks = 0;
   int errors = 0;

   // Stimulus and reference-model state.
   req_t            q0[$];
   req_t            q1[$];
   logic [N_DW-1:0] log0[$];
   logic [N_DW-1:0] log1[$];
   logic [N_DW-1:0] ref_mem [N_DP];
   logic [N_DW-1:0] sram_mem [N_DP];
   logic [1:0]      m_pend;
   logic [1:0]      m_old;
   logic [N_DW-1:0] m_data [2];
   logic            m_last;
   logic [1:0]      rdy = 2'b11;
   bit              rand_rdy = 1'b0;

   // Last observed values, for scenario-level checks.
   logic [1:0]      o_req_ready;
   logic [1:0]      o_rsp_valid;
   logic [N_DW-1:0] o_rdata [2];
   logic            o_csn;
   logic            o_wen;
   logic [N_DM-1:0] o_web;

   always #5 clk = ~clk;

   sram_sp_arb #(.N_DW(N_DW), .N_DP(N_DP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .sram_csn  (sram_csn),
      .sram_wen  (sram_wen),
      .sram_web  (sram_web),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
   );

   // Behavioural single-port SRAM: byte-masked write, 1-cycle read, dout 0
   // in any cycle that does not follow a read.
   always @(posedge clk) begin
      if (!sram_csn && !sram_wen) begin
         for (int b = 0; b < N_DM; b++) begin
            if (!sram_web[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
         end
      end
      sram_dout <= (!sram_csn && sram_wen) ? sram_mem[sram_addr] : '0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   function automatic req_t mk(input logic we, input logic [N_DM-1:0] be,
                               input logic [N_AW-1:0] addr, input logic [N_DW-1:0] wdata);
      req_t r;
      r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   task automatic reset_model();
      m_pend = '0;
      m_old  = '0;
      m_last = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   // One clock cycle: drive heads of the request queues, compare every DUT
   // output with the model, then advance the model across the edge.
   // Entered and left at a falling edge.
   task automatic step();
      req_t            h [2];
      logic [1:0]      el;
      logic            gv;
      logic            g;
      logic [1:0]      rr;
      logic [1:0]      exp_ready;
      logic [N_DM+N_AW+N_DW+1:0] exp_bus;
      logic [N_DM+N_AW+N_DW+1:0] act_bus;

      for (int p = 0; p < 2; p++) begin
         if ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0)) begin
            h[p] = (p == 0) ? q0[0] : q1[0];
            req_valid[p] = 1'b1;
         end else begin
            h[p] = mk(1'($urandom), N_DM'($urandom), N_AW'($urandom), $urandom);
            req_valid[p] = 1'b0;
         end
      end
      req_we    = {h[1].we, h[0].we};
      req_be    = {h[1].be, h[0].be};
      req_addr  = {h[1].addr, h[0].addr};
      req_wdata = {h[1].wdata, h[0].wdata};
      rsp_ready = rand_rdy ? 2'($urandom) : rdy;
      rr = rsp_ready;
      #1;

      checks++;
      if (rsp_valid !== m_pend) begin
         errors++;
         $display("FAIL rsp_valid @%0t: got %b expected %b", $time, rsp_valid, m_pend);
      end
      for (int p = 0; p < 2; p++) begin
         if (m_pend[p]) begin
            checks++;
            if (rsp_rdata[p*N_DW +: N_DW] !== m_data[p]) begin
               errors++;
               $display("FAIL rsp_rdata[%0d] @%0t: got %h expected %h", p, $time,
                        rsp_rdata[p*N_DW +: N_DW], m_data[p]);
            end
         end
      end

      // A response shown last cycle and not taken blocks its port even if
      // the requester is ready now; a fresh one blocks only if not ready.
      for (int p = 0; p < 2; p++) begin
         el[p] = req_valid[p] & ~(m_pend[p] & (m_old[p] | ~rr[p]));
      end
      gv = |el;
      g  = (el == 2'b11) ? ~m_last : el[1];
      exp_ready = gv ? (g ? 2'b10 : 2'b01) : 2'b00;
      if (gv) exp_bus = {1'b0, ~h[g].we, (h[g].we ? ~h[g].be : {N_DM{1'b1}}), h[g].addr, h[g].wdata};
      else    exp_bus = {1'b1, 1'b1, {N_DM{1'b1}}, {N_AW{1'b0}}, {N_DW{1'b0}}};
      act_bus = {sram_csn, sram_wen, sram_web, sram_addr, sram_din};

      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
      end
      checks++;
      if (act_bus !== exp_bus) begin
         errors++;
         $display("FAIL sram_bus @%0t: got csn=%b wen=%b web=%h addr=%h din=%h expected csn=%b wen=%b web=%h addr=%h din=%h",
                  $time, sram_csn, sram_wen, sram_web, sram_addr, sram_din,
                  exp_bus[N_DM+N_AW+N_DW+1], exp_bus[N_DM+N_AW+N_DW],
                  exp_bus[N_AW+N_DW +: N_DM], exp_bus[N_DW +: N_AW], exp_bus[0 +: N_DW]);
      end

      o_req_ready = req_ready;
      o_rsp_valid = rsp_valid;
      o_rdata[0]  = rsp_rdata[0 +: N_DW];
      o_rdata[1]  = rsp_rdata[N_DW +: N_DW];
      o_csn = sram_csn; o_wen = sram_wen; o_web = sram_web;
      if (rsp_valid[0] && rr[0]) log0.push_back(o_rdata[0]);
      if (rsp_valid[1] && rr[1]) log1.push_back(o_rdata[1]);

      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
         if (m_pend[p]) begin
            if (rr[p]) m_pend[p] = 1'b0;
            else       m_old[p]  = 1'b1;
         end
      end
      if (gv) begin
         m_pend[g] = 1'b1;
         m_old[g]  = 1'b0;
         m_data[g] = h[g].we ? '0 : ref_mem[h[g].addr];
         if (h[g].we) begin
            for (int b = 0; b < N_DM; b++) begin
               if (h[g].be[b]) ref_mem[h[g].addr][b*8 +: 8] = h[g].wdata[b*8 +: 8];
            end
         end
         m_last = g;
         if (g) void'(q1.pop_front());
         else   void'(q0.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      rand_rdy = 1'b0;
      rdy = 2'b11;
      while ((q0.size() > 0 || q1.size() > 0 || m_pend != 2'b00) && n < 64) begin
         step();
         n++;
      end
      checks++;
      if (q0.size() > 0 || q1.size() > 0 || m_pend != 2'b00) begin
         errors++;
         $display("FAIL drain: got q0=%0d q1=%0d pend=%b required all empty", q0.size(), q1.size(), m_pend);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      req_we    = 2'b01;
      rsp_ready = 2'b00;
      #2;
      checks++;
      if (req_ready !== 2'b00 || sram_csn !== 1'b1 || sram_wen !== 1'b1 ||
          sram_web !== {N_DM{1'b1}} || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold: got ready=%b csn=%b wen=%b web=%h rsp_valid=%b required 00/1/1/f/00",
                  req_ready, sram_csn, sram_wen, sram_web, rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (o_csn !== 1'b1 || o_wen !== 1'b1 || o_web !== {N_DM{1'b1}} || o_rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got csn=%b wen=%b web=%h rsp_valid=%b required 1/1/f/00",
                     i, o_csn, o_wen, o_web, o_rsp_valid);
         end
      end
   endtask

   task automatic test_write_read();
      rdy = 2'b11;
      q1.push_back(mk(1'b1, 4'hF, 9'd5, 32'hDEADBEEF));
      q1.push_back(mk(1'b0, 4'hF, 9'd5, 32'h0));
      step();
      checks++;
      if (o_req_ready !== 2'b10) begin
         errors++;
         $display("FAIL wr_issue: got ready=%b required 10", o_req_ready);
      end
      step();
      checks++;
      if (o_rsp_valid[1] !== 1'b1 || o_rdata[1] !== 32'h0) begin
         errors++;
         $display("FAIL wr_ack: got valid=%b data=%h required 1/00000000", o_rsp_valid[1], o_rdata[1]);
      end
      step();
      checks++;
      if (o_rsp_valid[1] !== 1'b1 || o_rdata[1] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_after_wr: got valid=%b data=%h required 1/deadbeef", o_rsp_valid[1], o_rdata[1]);
      end
      drain();
   endtask

   task automatic test_partial_write();
      q1.push_back(mk(1'b1, 4'hF, 9'd7, 32'h11223344));
      drain();
      log0.delete();
      q0.push_back(mk(1'b1, 4'h2, 9'd7, 32'hAABBCCDD));
      q0.push_back(mk(1'b0, 4'hF, 9'd7, 32'h0));
      drain();
      checks++;
      if (log0.size() != 2 || log0[log0.size()-1] !== 32'h1122CC44) begin
         errors++;
         $display("FAIL partial_write: got %0d responses last=%h required 2 with last 1122cc44",
                  log0.size(), (log0.size() > 0) ? log0[log0.size()-1] : 32'hx);
      end
   endtask

   task automatic test_backpressure();
      q1.push_back(mk(1'b1, 4'hF, 9'd3, 32'h00000055));
      drain();
      log0.delete();
      rdy = 2'b10;
      q0.push_back(mk(1'b0, 4'hF, 9'd3, 32'h0));
      q0.push_back(mk(1'b0, 4'hF, 9'd5, 32'h0));
      step();
      checks++;
      if (o_req_ready !== 2'b01) begin
         errors++;
         $display("FAIL bp_issue: got ready=%b required 01", o_req_ready);
      end
      for (int i = 0; i < 6; i++) q1.push_back(mk(1'b0, 4'hF, 9'($urandom_range(0, 15)), 32'h0));
      for (int i = 1; i < 5; i++) begin
         if (i == 4) rdy = 2'b11;
         step();
         checks++;
         if (o_rsp_valid[0] !== 1'b1 || o_rdata[0] !== 32'h55 || o_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: got valid0=%b data0=%h ready=%b required 1/00000055/10",
                     i, o_rsp_valid[0], o_rdata[0], o_req_ready);
         end
      end
      step();
      checks++;
      if (o_rsp_valid[0] !== 1'b0 || o_req_ready !== 2'b01 || log0.size() != 1) begin
         errors++;
         $display("FAIL bp_release: got valid0=%b ready=%b responses=%0d required 0/01/1",
                  o_rsp_valid[0], o_req_ready, log0.size());
      end
      drain();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      apply_reset();
      log0.delete();
      log1.delete();
      rdy = 2'b11;
      for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 4'hF, 9'(10 + i), 32'hA0 + i));
      q1.push_back(mk(1'b0, 4'hF, 9'd5, 32'h0));
      q1.push_back(mk(1'b0, 4'hF, 9'd7, 32'h0));
      q1.push_back(mk(1'b0, 4'hF, 9'd3, 32'h0));
      for (int i = 0; i < 6; i++) begin
         step();
         exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
         checks++;
         if (o_req_ready !== exp_g) begin
            errors++;
            $display("FAIL contention_grant %0d: got %b required %b", i, o_req_ready, exp_g);
         end
      end
      drain();
      checks++;
      if (log0.size() != 3 || log1.size() != 3 ||
          log1[0] !== 32'hDEADBEEF || log1[1] !== 32'h1122CC44 || log1[2] !== 32'h55 ||
          log0[0] !== 32'h0 || log0[1] !== 32'h0 || log0[2] !== 32'h0) begin
         errors++;
         $display("FAIL contention_rsp: got n0=%0d n1=%0d required 3 acks on p0 and deadbeef,1122cc44,00000055 on p1",
                  log0.size(), log1.size());
      end
   endtask

   task automatic test_async_reset();
      rdy = 2'b10;
      q0.push_back(mk(1'b0, 4'hF, 9'd3, 32'h0));
      step();
      q1.push_back(mk(1'b0, 4'hF, 9'd5, 32'h0));
      q1.push_back(mk(1'b0, 4'hF, 9'd7, 32'h0));
      step();
      req_valid = 2'b11;
      #2;
      checks++;
      if (rsp_valid !== 2'b11) begin
         errors++;
         $display("FAIL async_setup: got rsp_valid=%b required 11", rsp_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sram_csn !== 1'b1 || sram_wen !== 1'b1 || sram_web !== {N_DM{1'b1}} ||
          req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL async_reset: got csn=%b wen=%b web=%h ready=%b rsp_valid=%b required 1/1/f/00/00",
                  sram_csn, sram_wen, sram_web, req_ready, rsp_valid);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      rdy = 2'b11;
      log0.delete();
      log1.delete();
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (log0.size() != 0 || log1.size() != 0) begin
         errors++;
         $display("FAIL async_stale: got %0d/%0d responses after reset required 0/0", log0.size(), log1.size());
      end
   endtask

   task automatic test_random();
      rand_rdy = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (q0.size() < 3 && $urandom_range(0, 2) != 0)
            q0.push_back(mk(1'($urandom), N_DM'($urandom), 9'($urandom_range(0, 15)), $urandom));
         if (q1.size() < 3 && $urandom_range(0, 2) != 0)
            q1.push_back(mk(1'($urandom), N_DM'($urandom), 9'($urandom_range(0, 15)), $urandom));
         step();
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < N_DP; i++) begin
         ref_mem[i]  = '0;
         sram_mem[i] = '0;
      end
      reset_model();
      test_reset();
      test_write_read();
      test_partial_write();
      test_backpressure();
      test_contention();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
